// File: rtl/rijndael_pkg.sv
// Shared types and GF(2^8) helpers for the iterative Rijndael encryption controller.
// Byte k of a state/key vector sits at bits [8*(4*NB-1-k) +: 8] (byte 0 in the MSBs).
package rijndael_pkg;

  localparam int RW = 4;

  typedef enum logic [2:0] {IDLE, KEY0, ROUND, FINAL, DONE} state_e;

  function automatic bit legal_f(input int nb, input int nk);
    return (nb == 4 || nb == 6 || nb == 8) && (nk == 4 || nk == 6 || nk == 8);
  endfunction

  function automatic int nr_f(input int nb, input int nk);
    return ((nb > nk) ? nb : nk) + 6;
  endfunction

  // Row r rotates left by this many columns; wide blocks skip offset 2.
  function automatic int shift_f(input int nb, input int r);
    return (nb == 8 && r >= 2) ? r + 1 : r;
  endfunction

  // LSB-relative byte slot of state element (row r, column c).
  function automatic int bidx_f(input int nb, input int r, input int c);
    return 4*nb - 1 - (4*c + r);
  endfunction

  function automatic logic [7:0] xtime_f(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul_f(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime_f(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (0 maps to 0), then the affine transform.
  function automatic logic [7:0] sbox_f(input logic [7:0] a);
    logic [7:0] sq, inv;
    sq  = a;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gmul_f(sq, sq);
      inv = gmul_f(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] mixcol_f(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xtime_f(a0) ^ xtime_f(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime_f(a1) ^ xtime_f(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime_f(a2) ^ xtime_f(a3) ^ a3,
            xtime_f(a0) ^ a0 ^ a1 ^ a2 ^ xtime_f(a3)};
  endfunction

endpackage

// File: rtl/rijndael_round_dp.sv
// Single-cycle Rijndael round: SubBytes, ShiftRows, optional MixColumns, AddRoundKey.
module rijndael_round_dp
  import rijndael_pkg::*;
#(
  parameter int NB = 4
) (
  input  logic [32*NB-1:0] state,
  input  logic [32*NB-1:0] rk,
  input  logic             mix_en,
  output logic [32*NB-1:0] next
);

  localparam int SW = 32*NB;

  logic [SW-1:0] sub, shf, mix;

  for (genvar k = 0; k < 4*NB; k++) begin : g_sub
    assign sub[8*k +: 8] = sbox_f(state[8*k +: 8]);
  end

  for (genvar c = 0; c < NB; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int DST = bidx_f(NB, r, c);
      localparam int SRC = bidx_f(NB, r, (c + shift_f(NB, r)) % NB);
      assign shf[8*DST +: 8] = sub[8*SRC +: 8];
    end
    assign mix[32*(NB-1-c) +: 32] = mixcol_f(shf[32*(NB-1-c) +: 32]);
  end

  assign next = (mix_en ? mix : shf) ^ rk;

endmodule

// File: rtl/rijndael_round_ctrl.sv
// Iterative Rijndael encryption controller: one block in, NR+1 key additions through a
// shared round datapath, ciphertext held in the state register until the sink takes it.
module rijndael_round_ctrl
  import rijndael_pkg::*;
#(
  parameter int NB = 4,
  parameter int NK = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [32*NB-1:0] data_i,
  output logic             rk_req_o,
  output logic [RW-1:0]    rk_idx_o,
  input  logic             rk_valid_i,
  input  logic [32*NB-1:0] rk_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [32*NB-1:0] data_o,
  output logic             busy_o
);

  localparam int            NR   = nr_f(NB, NK);
  localparam logic [RW-1:0] NR_W = RW'(NR);

  if (!legal_f(NB, NK)) begin : g_bad_params
    $error("rijndael_round_ctrl: NB and NK must each be 4, 6 or 8");
  end

  state_e              fsm_q, fsm_d;
  logic [RW-1:0]       round_q, round_d;
  logic [32*NB-1:0]    state_q, state_d, dp_next;
  logic                mix_en;

  rijndael_round_dp #(.NB(NB)) u_dp (
    .state  (state_q),
    .rk     (rk_i),
    .mix_en (mix_en),
    .next   (dp_next)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fsm_q   <= IDLE;
      round_q <= '0;
      state_q <= '0;
    end else begin
      fsm_q   <= fsm_d;
      round_q <= round_d;
      state_q <= state_d;
    end
  end

  // A low rk_valid_i in a key state simply leaves every default (hold) in place.
  always_comb begin
    fsm_d   = fsm_q;
    round_d = round_q;
    state_d = state_q;
    mix_en  = 1'b1;
    case (fsm_q)
      IDLE: if (in_valid_i) begin
        state_d = data_i;
        round_d = '0;
        fsm_d   = KEY0;
      end
      KEY0: if (rk_valid_i) begin
        state_d = state_q ^ rk_i;
        round_d = RW'(1);
        fsm_d   = ROUND;
      end
      ROUND: if (rk_valid_i) begin
        state_d = dp_next;
        round_d = round_q + RW'(1);
        if (round_q + RW'(1) == NR_W) fsm_d = FINAL;
      end
      FINAL: begin
        mix_en = 1'b0;
        if (rk_valid_i) begin
          state_d = dp_next;
          fsm_d   = DONE;
        end
      end
      DONE: if (out_ready_i) begin
        round_d = '0;
        fsm_d   = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  assign in_ready_o  = (fsm_q == IDLE);
  assign busy_o      = (fsm_q != IDLE);
  assign rk_req_o    = (fsm_q == KEY0) || (fsm_q == ROUND) || (fsm_q == FINAL);
  assign out_valid_o = (fsm_q == DONE);
  assign rk_idx_o    = round_q;
  assign data_o      = state_q;

endmodule

// File: tb/tb_rijndael_round_ctrl.sv
// Bench for rijndael_round_ctrl: three instances (NB/NK = 4/4, 4/8, 8/8) driven by a key
// store model, with a byte-matrix Rijndael reference built from log/antilog S-box tables.
module tb_rijndael_round_ctrl;

  logic clk, rst;
  logic          in_valid [3];
  logic          rk_valid [3];
  logic          out_ready[3];
  logic [255:0]  din      [3];
  logic [255:0]  rk       [3];
  wire           in_ready [3];
  wire           rk_req   [3];
  wire           out_valid[3];
  wire           busy     [3];
  wire  [3:0]    rk_idx   [3];
  wire  [255:0]  dout     [3];
  wire  [127:0]  q0, q1;
  wire  [255:0]  q2;

  assign dout[0] = {128'h0, q0};
  assign dout[1] = {128'h0, q1};
  assign dout[2] = q2;

  rijndael_round_ctrl #(.NB(4), .NK(4)) u0 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]),
    .data_i(din[0][127:0]), .rk_req_o(rk_req[0]), .rk_idx_o(rk_idx[0]),
    .rk_valid_i(rk_valid[0]), .rk_i(rk[0][127:0]), .out_valid_o(out_valid[0]),
    .out_ready_i(out_ready[0]), .data_o(q0), .busy_o(busy[0]));

  rijndael_round_ctrl #(.NB(4), .NK(8)) u1 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]),
    .data_i(din[1][127:0]), .rk_req_o(rk_req[1]), .rk_idx_o(rk_idx[1]),
    .rk_valid_i(rk_valid[1]), .rk_i(rk[1][127:0]), .out_valid_o(out_valid[1]),
    .out_ready_i(out_ready[1]), .data_o(q1), .busy_o(busy[1]));

  rijndael_round_ctrl #(.NB(8), .NK(8)) u2 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid[2]), .in_ready_o(in_ready[2]),
    .data_i(din[2]), .rk_req_o(rk_req[2]), .rk_idx_o(rk_idx[2]),
    .rk_valid_i(rk_valid[2]), .rk_i(rk[2]), .out_valid_o(out_valid[2]),
    .out_ready_i(out_ready[2]), .data_o(q2), .busy_o(busy[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  bit [7:0]   sb [256];
  bit [255:0] rkeys [15];
  int         lat_cyc, stall_bad;
  bit         timed_out;
  int         idx_q [$];

  localparam bit [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;
  localparam bit [255:0] KEY_C1 = {128'h0, 128'h000102030405060708090a0b0c0d0e0f};
  localparam bit [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam bit [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam bit [127:0] CT_C3  = 128'h8ea2b7ca516745bfeafc49904b496089;

  // ---------------- reference model ----------------
  function automatic bit [7:0] xt(input bit [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic int nr_of(input int nb, input int nk);
    return ((nb > nk) ? nb : nk) + 6;
  endfunction

  // Walk the multiplicative group with generator 3 and its inverse in lockstep.
  task automatic build_sbox();
    bit [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sb[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;
  endtask

  function automatic bit [31:0] subw(input bit [31:0] t);
    return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
  endfunction

  task automatic expand(input int nb, input int nk, input bit [255:0] key);
    bit [31:0] w [120];
    bit [31:0] t;
    bit [7:0]  rc;
    int        nr;
    nr = nr_of(nb, nk);
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[32*(nk-1-i) +: 32];
    for (int i = nk; i < nb*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < 15; r++) begin
      rkeys[r] = '0;
      if (r <= nr)
        for (int c = 0; c < nb; c++) rkeys[r][32*(nb-1-c) +: 32] = w[r*nb + c];
    end
  endtask

  function automatic bit [255:0] ref_encrypt(input int nb, input int nk, input bit [255:0] pt);
    bit [7:0]   s [4][8];
    bit [7:0]   t [4][8];
    int         off [4];
    int         nr, pos;
    bit [7:0]   a0, a1, a2, a3;
    bit [255:0] ct;
    nr = nr_of(nb, nk);
    off[0] = 0; off[1] = 1; off[2] = (nb == 8) ? 3 : 2; off[3] = (nb == 8) ? 4 : 3;
    for (int c = 0; c < nb; c++)
      for (int r = 0; r < 4; r++) begin
        pos = 8*(4*nb - 1 - (4*c + r));
        s[r][c] = pt[pos +: 8] ^ rkeys[0][pos +: 8];
      end
    for (int rnd = 1; rnd <= nr; rnd++) begin
      for (int c = 0; c < nb; c++)
        for (int r = 0; r < 4; r++) t[r][c] = sb[s[r][(c + off[r]) % nb]];
      if (rnd < nr)
        for (int c = 0; c < nb; c++) begin
          a0 = t[0][c]; a1 = t[1][c]; a2 = t[2][c]; a3 = t[3][c];
          t[0][c] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          t[1][c] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          t[2][c] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          t[3][c] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      for (int c = 0; c < nb; c++)
        for (int r = 0; r < 4; r++) begin
          pos = 8*(4*nb - 1 - (4*c + r));
          s[r][c] = t[r][c] ^ rkeys[rnd][pos +: 8];
        end
    end
    ct = '0;
    for (int c = 0; c < nb; c++)
      for (int r = 0; r < 4; r++) ct[8*(4*nb - 1 - (4*c + r)) +: 8] = s[r][c];
    return ct;
  endfunction

  function automatic bit [255:0] rnd_vec(input int nbits);
    bit [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
    return (nbits == 256) ? v : {128'h0, v[127:0]};
  endfunction

  // ---------------- stimulus drivers ----------------
  task automatic start_block(input int u, input bit [255:0] pt);
    @(negedge clk);
    din[u]      = pt;
    in_valid[u] = 1'b1;
    @(posedge clk);
    #1;
    in_valid[u] = 1'b0;
  endtask

  // Serve round keys until out_valid (or until rk_idx reaches stop_idx); lat_cyc counts
  // cycles from the accept cycle to the cycle where the loop stopped.
  task automatic pump(input int u, input int pct, input int stop_idx);
    bit [255:0] prev;
    bit         stalled, done;
    lat_cyc = 0; stall_bad = 0; timed_out = 1'b1; idx_q.delete();
    done = 1'b0;
    for (int n = 0; n < 500 && !done; n++) begin
      @(negedge clk);
      lat_cyc++;
      if (out_valid[u] || (stop_idx >= 0 && rk_req[u] && int'(rk_idx[u]) == stop_idx)) begin
        timed_out = 1'b0;
        done = 1'b1;
      end else begin
        rk[u]       = rkeys[rk_idx[u]];
        rk_valid[u] = ($urandom_range(99) < pct);
        stalled     = rk_req[u] && !rk_valid[u];
        if (rk_req[u] && rk_valid[u]) idx_q.push_back(int'(rk_idx[u]));
        prev = dout[u];
        @(posedge clk);
        #1;
        if (stalled && dout[u] !== prev) stall_bad++;
      end
    end
    rk_valid[u] = 1'b0;
  endtask

  task automatic finish_block(input int u);
    @(negedge clk);
    out_ready[u] = 1'b1;
    @(posedge clk);
    #1;
    out_ready[u] = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int u = 0; u < 3; u++) begin
      checks++;
      if (in_ready[u] !== 1'b1 || rk_req[u] !== 1'b0 || rk_idx[u] !== 4'd0 ||
          out_valid[u] !== 1'b0 || busy[u] !== 1'b0) begin
        errors++;
        $display("FAIL reset_ctrl[%0d]: got rdy=%b req=%b idx=%0d ov=%b busy=%b, want 1 0 0 0 0",
                 u, in_ready[u], rk_req[u], rk_idx[u], out_valid[u], busy[u]);
      end
      checks++;
      if (dout[u] !== 256'h0) begin
        errors++;
        $display("FAIL reset_state[%0d]: got %h want 0", u, dout[u]);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_fips128();
    expand(4, 4, KEY_C1);
    start_block(0, {128'h0, PT_C});
    pump(0, 100, -1);
    checks++;
    if (timed_out) begin errors++; $display("FAIL c1_timeout: no out_valid within bound"); end
    checks++;
    if (lat_cyc != 12) begin errors++; $display("FAIL c1_latency: got %0d want 12", lat_cyc); end
    checks++;
    if (dout[0][127:0] !== CT_C1) begin
      errors++; $display("FAIL c1_ct: got %h want %h", dout[0][127:0], CT_C1);
    end
    checks++;
    if (in_ready[0] !== 1'b0) begin errors++; $display("FAIL c1_ready_in_done: got %b want 0", in_ready[0]); end
    finish_block(0);
    checks++;
    if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0 || rk_idx[0] !== 4'd0) begin
      errors++;
      $display("FAIL c1_after_handshake: got rdy=%b ov=%b idx=%0d want 1 0 0",
               in_ready[0], out_valid[0], rk_idx[0]);
    end
  endtask

  task automatic test_fips256();
    bit ok;
    expand(4, 8, KEY_C3);
    start_block(1, {128'h0, PT_C});
    pump(1, 100, -1);
    checks++;
    if (timed_out) begin errors++; $display("FAIL c3_timeout: no out_valid within bound"); end
    checks++;
    if (lat_cyc != 16) begin errors++; $display("FAIL c3_latency: got %0d want 16", lat_cyc); end
    checks++;
    if (dout[1][127:0] !== CT_C3) begin
      errors++; $display("FAIL c3_ct: got %h want %h", dout[1][127:0], CT_C3);
    end
    ok = (idx_q.size() == 15);
    for (int i = 0; i < idx_q.size(); i++) if (idx_q[i] != i) ok = 1'b0;
    checks++;
    if (!ok) begin
      errors++; $display("FAIL c3_idx_walk: got %0d keys, want indices 0..14 in order", idx_q.size());
    end
    checks++;
    if (rk_idx[1] !== 4'd14) begin errors++; $display("FAIL c3_idx_done: got %0d want 14", rk_idx[1]); end
    finish_block(1);
  endtask

  task automatic test_stall();
    expand(4, 4, KEY_C1);
    start_block(0, {128'h0, PT_C});
    pump(0, 50, -1);
    checks++;
    if (timed_out) begin errors++; $display("FAIL stall_timeout: no out_valid within bound"); end
    checks++;
    if (dout[0][127:0] !== CT_C1) begin
      errors++; $display("FAIL stall_ct: got %h want %h", dout[0][127:0], CT_C1);
    end
    checks++;
    if (stall_bad != 0) begin
      errors++; $display("FAIL stall_hold: state changed in %0d stalled cycles, want 0", stall_bad);
    end
    finish_block(0);
  endtask

  task automatic test_backpressure();
    expand(4, 4, KEY_C1);
    start_block(0, {128'h0, PT_C});
    pump(0, 100, -1);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid[0] !== 1'b1 || in_ready[0] !== 1'b0 || dout[0][127:0] !== CT_C1) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got ov=%b rdy=%b data=%h want 1 0 %h",
                 i, out_valid[0], in_ready[0], dout[0][127:0], CT_C1);
      end
      din[0]      = rnd_vec(128);
      in_valid[0] = 1'b1;
      @(posedge clk);
      #1;
      in_valid[0] = 1'b0;
      @(negedge clk);
    end
    finish_block(0);
    @(negedge clk);
    checks++;
    if (busy[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
      errors++; $display("FAIL bp_ignored: got busy=%b rdy=%b want 0 1", busy[0], in_ready[0]);
    end
    out_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    out_ready[0] = 1'b0;
    checks++;
    if (busy[0] !== 1'b0 || out_valid[0] !== 1'b0) begin
      errors++; $display("FAIL idle_out_ready: got busy=%b ov=%b want 0 0", busy[0], out_valid[0]);
    end
  endtask

  task automatic test_reset_mid();
    expand(4, 4, KEY_C1);
    start_block(0, rnd_vec(128));
    pump(0, 100, 5);
    checks++;
    if (timed_out) begin errors++; $display("FAIL rstmid_reach: round 5 not reached"); end
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready[0] !== 1'b1 || rk_req[0] !== 1'b0 || rk_idx[0] !== 4'd0 ||
        out_valid[0] !== 1'b0 || busy[0] !== 1'b0 || dout[0] !== 256'h0) begin
      errors++;
      $display("FAIL rstmid_values: got rdy=%b req=%b idx=%0d ov=%b busy=%b data=%h",
               in_ready[0], rk_req[0], rk_idx[0], out_valid[0], busy[0], dout[0][127:0]);
    end
    rst = 1'b0;
    start_block(0, {128'h0, PT_C});
    pump(0, 100, -1);
    checks++;
    if (timed_out || dout[0][127:0] !== CT_C1) begin
      errors++; $display("FAIL rstmid_next_ct: got %h want %h", dout[0][127:0], CT_C1);
    end
    finish_block(0);
  endtask

  task automatic test_back_to_back();
    bit [255:0] key, pt, exp_ct;
    for (int n = 0; n < 20; n++) begin
      key = rnd_vec(128);
      pt  = rnd_vec(128);
      expand(4, 4, key);
      exp_ct = ref_encrypt(4, 4, pt);
      checks++;
      if (in_ready[0] !== 1'b1) begin
        errors++; $display("FAIL b2b_ready[%0d]: got %b want 1", n, in_ready[0]);
      end
      start_block(0, pt);
      pump(0, 80, -1);
      checks++;
      if (timed_out || dout[0] !== exp_ct) begin
        errors++; $display("FAIL b2b_ct[%0d]: got %h want %h", n, dout[0][127:0], exp_ct[127:0]);
      end
      finish_block(0);
    end
  endtask

  task automatic test_random_nb8();
    bit [255:0] key, pt, exp_ct;
    for (int n = 0; n < 1000; n++) begin
      key = rnd_vec(256);
      pt  = rnd_vec(256);
      expand(8, 8, key);
      exp_ct = ref_encrypt(8, 8, pt);
      start_block(2, pt);
      pump(2, 75, -1);
      checks++;
      if (timed_out || dout[2] !== exp_ct) begin
        errors++; $display("FAIL nb8_ct[%0d]: got %h want %h", n, dout[2], exp_ct);
      end
      finish_block(2);
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int u = 0; u < 3; u++) begin
      in_valid[u] = 1'b0; rk_valid[u] = 1'b0; out_ready[u] = 1'b0;
      din[u] = '0; rk[u] = '0;
    end
    build_sbox();
    test_reset();
    test_fips128();
    test_fips256();
    test_stall();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random_nb8();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
